// File: rtl/usb_rx_pkt_fifo_if.sv
// Signal bundle between the USB packet receiver, the packet FIFO and the SD-side reader.
// The ovfl_clr/ovfl_err pair exists only when USB_RX_FIFO_OVFL_EN is defined.
interface usb_rx_pkt_fifo_if #(
   parameter int ADDR_W = 6
) ();
   logic              pckt_start;
   logic              w_enable;
   logic [7:0]        w_data;
   logic              pckt_end;
   logic              crc_status;
   logic              r_enable;
   logic [7:0]        r_data;
   logic              empty;
   logic              fifo_full;
   logic [ADDR_W:0]   count;
   logic              pkt_committed;
   logic              pkt_dropped;
`ifdef USB_RX_FIFO_OVFL_EN
   logic              ovfl_clr;
   logic              ovfl_err;
`endif

   // FIFO side
   modport slave (
`ifdef USB_RX_FIFO_OVFL_EN
      input  ovfl_clr,
      output ovfl_err,
`endif
      input  pckt_start, w_enable, w_data, pckt_end, crc_status, r_enable,
      output r_data, empty, fifo_full, count, pkt_committed, pkt_dropped
   );

   // Receiver / reader side
   modport master (
`ifdef USB_RX_FIFO_OVFL_EN
      output ovfl_clr,
      input  ovfl_err,
`endif
      output pckt_start, w_enable, w_data, pckt_end, crc_status, r_enable,
      input  r_data, empty, fifo_full, count, pkt_committed, pkt_dropped
   );
endinterface

// File: rtl/usb_rx_pkt_fifo.sv
// Speculative USB receive byte FIFO: bytes are committed on good CRC, rewound on bad CRC/abort.
// Optional sticky overflow flag (ovfl_err, ovfl_clr) is enabled by defining USB_RX_FIFO_OVFL_EN.
module usb_rx_pkt_fifo #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              sysclk,
   input  logic              n_rst,
   usb_rx_pkt_fifo_if.slave  bus
);
   typedef logic [ADDR_W:0] ptr_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RCV,
      ST_DROP
   } state_t;

   localparam ptr_t FULL_OCC = ptr_t'(DEPTH);

   logic [7:0] mem [DEPTH];

   state_t state_q;
   ptr_t   wr_ptr_q;
   ptr_t   cm_ptr_q;
   ptr_t   rd_ptr_q;
   ptr_t   rd_ptr_d;
   ptr_t   wr_inc;
   ptr_t   count_w;
   logic   empty_w;
   logic   full_w;
   logic   in_rcv;
   logic   wr_ok;
   logic   overflow;
   logic   pop;
   logic   pkt_committed_q;
   logic   pkt_dropped_q;

   // Occupancy flags depend only on registered pointers.
   assign count_w  = cm_ptr_q - rd_ptr_q;
   assign empty_w  = (count_w == '0);
   assign full_w   = (ptr_t'(wr_ptr_q - rd_ptr_q) == FULL_OCC);

   // pckt_start wins over any same-cycle byte: the old packet is being aborted.
   assign in_rcv   = (state_q == ST_RCV);
   assign wr_ok    = in_rcv && bus.w_enable && !full_w && !bus.pckt_start;
   assign overflow = in_rcv && bus.w_enable &&  full_w && !bus.pckt_start;
   assign pop      = bus.r_enable && !empty_w;
   assign wr_inc   = wr_ptr_q + ptr_t'(wr_ok);
   assign rd_ptr_d = rd_ptr_q + ptr_t'(pop);

   // NOTE: the storage array has no reset; only pointers define which entries are valid.
   always_ff @(posedge sysclk) begin
      if (wr_ok) begin
         mem[wr_ptr_q[ADDR_W-1:0]] <= bus.w_data;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge sysclk or negedge n_rst) begin
      if (!n_rst) begin
         rd_ptr_q <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge sysclk or negedge n_rst) begin
      if (!n_rst) begin
         state_q         <= ST_IDLE;
         wr_ptr_q        <= '0;
         cm_ptr_q        <= '0;
         pkt_committed_q <= 1'b0;
         pkt_dropped_q   <= 1'b0;
      end else begin
         pkt_committed_q <= 1'b0;
         pkt_dropped_q   <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (bus.pckt_start) begin
                  state_q <= ST_RCV;
               end
            end
            ST_RCV: begin
               if (bus.pckt_start) begin
                  wr_ptr_q      <= cm_ptr_q;
                  pkt_dropped_q <= 1'b1;
               end else if (overflow) begin
                  // A lost byte poisons the packet; an EOP in the same cycle closes it at once.
                  if (bus.pckt_end) begin
                     wr_ptr_q      <= cm_ptr_q;
                     pkt_dropped_q <= 1'b1;
                     state_q       <= ST_IDLE;
                  end else begin
                     state_q       <= ST_DROP;
                  end
               end else if (bus.pckt_end) begin
                  if (bus.crc_status) begin
                     wr_ptr_q        <= wr_inc;
                     cm_ptr_q        <= wr_inc;
                     pkt_committed_q <= 1'b1;
                  end else begin
                     wr_ptr_q        <= cm_ptr_q;
                     pkt_dropped_q   <= 1'b1;
                  end
                  state_q <= ST_IDLE;
               end else begin
                  wr_ptr_q <= wr_inc;
               end
            end
            ST_DROP: begin
               if (bus.pckt_start) begin
                  wr_ptr_q      <= cm_ptr_q;
                  pkt_dropped_q <= 1'b1;
                  state_q       <= ST_RCV;
               end else if (bus.pckt_end) begin
                  wr_ptr_q      <= cm_ptr_q;
                  pkt_dropped_q <= 1'b1;
                  state_q       <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef USB_RX_FIFO_OVFL_EN
   logic ovfl_err_q;

   // Set wins over clear so an overflow in the clearing cycle is never lost.
   always_ff @(posedge sysclk or negedge n_rst) begin
      if (!n_rst) begin
         ovfl_err_q <= 1'b0;
      end else if (overflow) begin
         ovfl_err_q <= 1'b1;
      end else if (bus.ovfl_clr) begin
         ovfl_err_q <= 1'b0;
      end
   end

   assign bus.ovfl_err = ovfl_err_q;
`endif

   assign bus.count         = count_w;
   assign bus.empty         = empty_w;
   assign bus.fifo_full     = full_w;
   assign bus.r_data        = empty_w ? 8'h00 : mem[rd_ptr_q[ADDR_W-1:0]];
   assign bus.pkt_committed = pkt_committed_q;
   assign bus.pkt_dropped   = pkt_dropped_q;

endmodule

// File: tb/tb_usb_rx_pkt_fifo.sv
// Self-checking bench for usb_rx_pkt_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based packet model.
module tb_usb_rx_pkt_fifo;
   localparam int DEPTH  = 64;
   localparam int ADDR_W = 6;

   logic sysclk = 1'b0;
   logic n_rst  = 1'b1;

   usb_rx_pkt_fifo_if #(.ADDR_W(ADDR_W)) bus ();

   usb_rx_pkt_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .sysclk (sysclk),
      .n_rst  (n_rst),
      .bus    (bus)
   );

   always #5 sysclk = ~sysclk;

   int n_tests = 0;
   int n_fail  = 0;

   // Model: committed bytes, bytes of the open packet, and packet phase.
   logic [7:0] m_cq[$];
   logic [7:0] m_pend[$];
   int         m_phase;   // 0 = waiting for packet, 1 = receiving, 2 = discarding
   bit         m_commit;
   bit         m_drop;
   bit         m_ovfl;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_cq.delete();
      m_pend.delete();
      m_phase  = 0;
      m_commit = 0;
      m_drop   = 0;
      m_ovfl   = 0;
   endtask

   task automatic model_step(input bit s, input bit w, input logic [7:0] d,
                             input bit e, input bit c, input bit r, input bit clr);
      bit full;
      bit lost;
      full     = (m_cq.size() + m_pend.size()) == DEPTH;
      lost     = 0;
      m_commit = 0;
      m_drop   = 0;
      if (r && m_cq.size() > 0) void'(m_cq.pop_front());
      case (m_phase)
         0: if (s) m_phase = 1;
         1: begin
            if (s) begin
               m_pend.delete();
               m_drop = 1;
            end else begin
               if (w) begin
                  if (full) lost = 1;
                  else m_pend.push_back(d);
               end
               if (lost && !e) begin
                  m_phase = 2;
               end else if (e) begin
                  if (c && !lost) begin
                     foreach (m_pend[i]) m_cq.push_back(m_pend[i]);
                     m_commit = 1;
                  end else begin
                     m_drop = 1;
                  end
                  m_pend.delete();
                  m_phase = 0;
               end
            end
         end
         default: begin
            if (s || e) begin
               m_pend.delete();
               m_drop  = 1;
               m_phase = s ? 1 : 0;
            end
         end
      endcase
      if (lost) m_ovfl = 1;
      else if (clr) m_ovfl = 0;
   endtask

   task automatic compare_outputs();
      logic [7:0] exp_rd;
      exp_rd = (m_cq.size() > 0) ? m_cq[0] : 8'h00;
      check("count",     32'(bus.count),         32'(m_cq.size()));
      check("empty",     32'(bus.empty),         32'(m_cq.size() == 0));
      check("fifo_full", 32'(bus.fifo_full),     32'((m_cq.size() + m_pend.size()) == DEPTH));
      check("r_data",    32'(bus.r_data),        32'(exp_rd));
      check("committed", 32'(bus.pkt_committed), 32'(m_commit));
      check("dropped",   32'(bus.pkt_dropped),   32'(m_drop));
`ifdef USB_RX_FIFO_OVFL_EN
      check("ovfl_err",  32'(bus.ovfl_err),      32'(m_ovfl));
`endif
   endtask

   task automatic cyc(input bit s, input bit w, input logic [7:0] d,
                      input bit e, input bit c, input bit r, input bit clr);
      bus.pckt_start = s;
      bus.w_enable   = w;
      bus.w_data     = d;
      bus.pckt_end   = e;
      bus.crc_status = c;
      bus.r_enable   = r;
`ifdef USB_RX_FIFO_OVFL_EN
      bus.ovfl_clr   = clr;
`endif
      model_step(s, w, d, e, c, r, clr);
      @(posedge sysclk);
      #1;
      compare_outputs();
   endtask

   task automatic idle_cyc();
      cyc(0, 0, 8'h00, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      n_rst = 1'b0;
      bus.pckt_start = 0; bus.w_enable = 0; bus.w_data = 0;
      bus.pckt_end = 0; bus.crc_status = 0; bus.r_enable = 0;
`ifdef USB_RX_FIFO_OVFL_EN
      bus.ovfl_clr = 0;
`endif
      model_clear();
      #2;
      compare_outputs();
      @(negedge sysclk);
      n_rst = 1'b1;
   endtask

   task automatic write_bytes(input int n, input int base);
      for (int i = 0; i < n; i++) cyc(0, 1, 8'(base + i), 0, 0, 0, 0);
   endtask

   task automatic send_pkt(input int n, input int base, input bit crc);
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      write_bytes(n, base);
      cyc(0, 0, 8'h00, 1, crc, 0, 0);
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (m_cq.size() > 0 && guard < 4 * DEPTH) begin
         cyc(0, 0, 8'h00, 0, 0, 1, 0);
         guard++;
      end
      idle_cyc();
   endtask

   initial begin
      model_clear();
      #1;
      do_reset();
      idle_cyc();

      // Basic 4-byte good packet, then drained.
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      cyc(0, 1, 8'hA1, 0, 0, 0, 0);
      cyc(0, 1, 8'hB2, 0, 0, 0, 0);
      cyc(0, 1, 8'hC3, 0, 0, 0, 0);
      cyc(0, 1, 8'hD4, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 1, 1, 0, 0);
      check("first_commit_count", 32'(bus.count), 32'd4);
      check("first_commit_head",  32'(bus.r_data), 32'hA1);
      drain();

      // Bad CRC packet, then a good two-byte packet.
      send_pkt(3, 8'h50, 0);
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      cyc(0, 1, 8'h11, 0, 0, 0, 0);
      cyc(0, 1, 8'h22, 0, 0, 0, 0);
      cyc(0, 0, 8'h00, 1, 1, 0, 0);
      drain();

      // Exactly DEPTH bytes: full before commit, pop releases one slot.
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      write_bytes(DEPTH, 0);
      check("full_after_64", 32'(bus.fifo_full), 32'd1);
      cyc(0, 0, 8'h00, 1, 1, 0, 0);
      cyc(0, 0, 8'h00, 0, 0, 1, 0);
      check("full_after_pop", 32'(bus.fifo_full), 32'd0);
      drain();

      // Overflow with 60 committed bytes, then clear of the sticky flag.
      send_pkt(60, 8'h80, 1);
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      write_bytes(5, 8'hE0);
      cyc(0, 0, 8'h00, 1, 1, 0, 0);
      check("ovfl_count", 32'(bus.count), 32'd60);
      idle_cyc();
      cyc(0, 0, 8'h00, 0, 0, 0, 1);
      drain();

      // Zero-length packet and abort by a second pckt_start.
      send_pkt(0, 0, 1);
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      write_bytes(3, 8'h30);
      send_pkt(2, 8'h70, 1);
      drain();

      // Pointer wrap-around.
      for (int k = 0; k < 3; k++) begin
         send_pkt(40, 8'(k * 40), 1);
         drain();
      end

      // Reset during an open packet with committed data present.
      send_pkt(10, 8'h10, 1);
      cyc(1, 0, 8'h00, 0, 0, 0, 0);
      write_bytes(3, 8'hC0);
      do_reset();
      for (int i = 0; i < 4; i++) cyc(0, 1, 8'(8'hF0 + i), (i == 3), 1, 0, 0);
      check("post_reset_count", 32'(bus.count), 32'd0);

      // Random traffic: a drain-friendly phase and a fill-heavy phase.
      for (int ph = 0; ph < 2; ph++) begin
         for (int i = 0; i < 1500; i++) begin
            bit s, w, e, c, r, clr;
            s   = ($urandom_range(99, 0) < 3);
            w   = ($urandom_range(99, 0) < 70);
            e   = ($urandom_range(99, 0) < (ph == 0 ? 8 : 3));
            c   = ($urandom_range(99, 0) < 80);
            r   = ($urandom_range(99, 0) < (ph == 0 ? 50 : 8));
            clr = ($urandom_range(99, 0) < 2);
            cyc(s, w, 8'($urandom), e, c, r, clr);
         end
      end
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
